pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Registered next-PC unit for the 5-stage MIPS pipeline; successor to the combinational next-PC logic.
- Owns the PC register and computes sequential, branch, J and JR targets at parametrised width.
- Arbitrates decode redirects against late-stage flushes.
- Buffers a redirect that arrives during a stall.
- Supports halt/resume control from the CPU controller.

Parameters:
- PC_W, 32, PC register width in bits; byte address; bits [1:0] always 0.
- IMEM_AW, 12, width of the instruction-memory address output; equals pc[IMEM_AW-1:0].
- RESET_PC, 0, PC value loaded at reset; must be word aligned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit freezes the PC.
- redir_valid  in  1  decode-stage redirect request, single-cycle.
- redir_sel  in  2  0 SEQ, 1 BRANCH, 2 J, 3 JR.
- cond_taken  in  1  branch condition; used only when redir_sel=1.
- instr  in  32  instruction in decode; supplies imm16 and imm26.
- dec_pc4  in  PC_W  PC+4 of the decode instruction.
- reg_a  in  PC_W  rs value for JR.
- flush_valid  in  1  late-stage flush (exception or eret).
- flush_pc  in  PC_W  flush target.
- halt  in  1  enter HALT.
- resume  in  1  leave HALT.
- pc  out  PC_W  current fetch PC.
- imem_addr  out  IMEM_AW  pc[IMEM_AW-1:0].
- redirected  out  1  PC was loaded from a non-sequential source this cycle; used to squash the fetch stage.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset (asynchronous, rst_n=0): pc=RESET_PC, state=RUN, pend_valid=0, redirected=0, halted=0. Release is synchronous to the next clk edge.
- Target computation (combinational):
  - BRANCH target = dec_pc4 + (sext(imm16)<<2), modulo 2^PC_W.
  - J target = {dec_pc4[PC_W-1:28], imm26, 2'b00}. When PC_W≤28, use {imm26,00}[PC_W-1:0].
  - JR target = {reg_a[PC_W-1:2], 2'b00}; the low bits are forced to 0.
- Effective redirect: redir_valid && (redir_sel==J || redir_sel==JR || (redir_sel==BRANCH && cond_taken)). SEQ, or BRANCH with cond_taken=0, is not a redirect.
- FSM states: RUN, PEND, HALT.
  - RUN: update priority is flush > redirect > stall > sequential.
    - flush_valid: pc<=flush_pc.
    - Effective redirect with stall=0: pc<=target.
    - Effective redirect with stall=1: latch the target into pend_pc, go to PEND; pc holds.
    - stall=1 otherwise: pc holds.
    - Else: pc<=pc+4, wrapping at 2^PC_W.
  - PEND: pc holds while stall=1.
    - First cycle with stall=0: pc<=pend_pc, go to RUN.
    - flush_valid in PEND: pc<=flush_pc, pend discarded, go to RUN.
    - A new redir_valid in PEND is ignored (decode is frozen).
  - HALT: entered from RUN or PEND on halt=1 (flush has priority in the same cycle).
    - pc holds; pend is retained.
    - resume=1 returns to PEND if pend is valid, else RUN.
    - halt and resume both high: halt wins.
    - flush_valid in HALT: pc<=flush_pc, state unchanged, pend cleared.
- redirected is registered: 1 for exactly one cycle after any non-sequential load (flush, redirect, pend release).
- halted equals (state==HALT), registered.
- Latency: a redirect or flush sampled at edge N is visible on pc after edge N.

Optional Feature:
- PC_REDIR_CNT_EN defined:
  - Adds output port redir_cnt (32 bits).
  - Reset to 0; increments once per cycle in which redirected is asserted.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pc_pkg holds:
  - redir_sel encodings SEL_SEQ/SEL_BRANCH/SEL_J/SEL_JR.
  - State encodings ST_RUN/ST_PEND/ST_HALT.
  - Constant INSTR_STEP=4.
- Sub-module pc_target_calc: combinational BRANCH/J/JR target and effective-redirect flag. The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset and sequential: rst_n low then high, RESET_PC=0x0, no stimulus.
  - pc=0x0 during reset, then 0x4, 0x8, 0xC on successive cycles.
  - redirected stays 0.
- Backward branch: dec_pc4=0x100, imm16=0xFFFC, redir_sel=1, cond_taken=1.
  - pc=0xF0 next cycle; redirected=1 for one cycle.
  - With cond_taken=0: pc=prev+4.
- J, JR and wrap:
  - imm26=0x0000040, dec_pc4=0x1000_0004: pc=0x1000_0100.
  - JR with reg_a=0x203: pc=0x200.
  - pc=0xFFFF_FFFC sequential: pc=0x0.
- Stalled redirect: J to 0x80 with stall=1 for 3 cycles.
  - pc holds 3 cycles; state=PEND.
  - pc=0x80 on the first unstalled edge.
  - A second redir_valid during the stall is ignored.
- Priority and halt:
  - flush_valid (flush_pc=0x180) together with a branch redirect: pc=0x180.
  - halt then resume: pc frozen, halted=1, then sequential stepping restarts.
  - Assert rst_n low mid-PEND: pc=RESET_PC immediately, pend cleared.
- With PC_REDIR_CNT_EN defined: 5 redirects plus 1 flush give redir_cnt=6.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared encodings and constants for the next-PC sequencer
package pc_pkg;

    localparam logic [1:0] SEL_SEQ    = 2'd0;
    localparam logic [1:0] SEL_BRANCH = 2'd1;
    localparam logic [1:0] SEL_J      = 2'd2;
    localparam logic [1:0] SEL_JR     = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int INSTR_STEP = 4;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational BRANCH/J/JR target and effective-redirect flag
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            i_redir_valid,
    input  logic [1:0]      i_redir_sel,
    input  logic            i_cond_taken,
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_dec_pc4,
    input  logic [PC_W-1:0] i_reg_a,
    output logic [PC_W-1:0] o_target,
    output logic            o_redir_eff
);

    logic signed [31:0] w_boff32;
    logic [PC_W-1:0]    w_boff;
    logic [PC_W-1:0]    w_branch;
    logic [PC_W-1:0]    w_jump;
    logic [PC_W-1:0]    w_jr;
    logic [27:0]        w_j28;
    logic               w_unused;

    assign w_boff32 = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
    assign w_boff   = PC_W'(w_boff32);
    assign w_branch = i_dec_pc4 + w_boff;
    assign w_j28    = {i_instr[25:0], 2'b00};
    assign w_jr     = {i_reg_a[PC_W-1:2], 2'b00};
    assign w_unused = &{1'b0, i_instr[31:26], i_reg_a[1:0]};

    // J keeps the region bits of PC+4 only when the PC is wider than the 28-bit field
    generate
        if (PC_W > 28) begin : g_j_wide
            assign w_jump = {i_dec_pc4[PC_W-1:28], w_j28};
        end else begin : g_j_narrow
            assign w_jump = w_j28[PC_W-1:0];
        end
    endgenerate

    always_comb begin
        o_target = w_branch;
        case (i_redir_sel)
            SEL_J:   o_target = w_jump;
            SEL_JR:  o_target = w_jr;
            default: o_target = w_branch;
        endcase
    end

    assign o_redir_eff = i_redir_valid &&
                         ((i_redir_sel == SEL_J) || (i_redir_sel == SEL_JR) ||
                          ((i_redir_sel == SEL_BRANCH) && i_cond_taken));

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered next-PC unit with stall-buffered redirect and halt control
// Optional redirect counter output redir_cnt enabled by PC_REDIR_CNT_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              IMEM_AW  = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redir_valid,
    input  logic [1:0]         redir_sel,
    input  logic               cond_taken,
    input  logic [31:0]        instr,
    input  logic [PC_W-1:0]    dec_pc4,
    input  logic [PC_W-1:0]    reg_a,
    input  logic               flush_valid,
    input  logic [PC_W-1:0]    flush_pc,
    input  logic               halt,
    input  logic               resume,
    output logic [PC_W-1:0]    pc,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               redirected,
    output logic               halted
`ifdef PC_REDIR_CNT_EN
    ,
    output logic [31:0]        redir_cnt
`endif
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_pend_pc;
    logic            r_pend_valid;
    logic            r_redirected;
    logic            r_halted;
    logic [PC_W-1:0] w_target;
    logic            w_redir_eff;

    pc_target_calc #(.PC_W(PC_W)) u_target (
        .i_redir_valid (redir_valid),
        .i_redir_sel   (redir_sel),
        .i_cond_taken  (cond_taken),
        .i_instr       (instr),
        .i_dec_pc4     (dec_pc4),
        .i_reg_a       (reg_a),
        .o_target      (w_target),
        .o_redir_eff   (w_redir_eff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_pend_pc    <= '0;
            r_pend_valid <= 1'b0;
            r_redirected <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_redirected <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (flush_valid) begin
                        r_pc         <= flush_pc;
                        r_redirected <= 1'b1;
                    end else if (halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (w_redir_eff && !stall) begin
                        r_pc         <= w_target;
                        r_redirected <= 1'b1;
                    end else if (w_redir_eff) begin
                        r_pend_pc    <= w_target;
                        r_pend_valid <= 1'b1;
                        r_state      <= ST_PEND;
                    end else if (!stall) begin
                        r_pc <= r_pc + PC_W'(INSTR_STEP);
                    end
                end
                ST_PEND: begin
                    // decode is frozen here, so any new redirect request is ignored
                    if (flush_valid) begin
                        r_pc         <= flush_pc;
                        r_redirected <= 1'b1;
                        r_pend_valid <= 1'b0;
                        r_state      <= ST_RUN;
                    end else if (halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (!stall) begin
                        r_pc         <= r_pend_pc;
                        r_redirected <= 1'b1;
                        r_pend_valid <= 1'b0;
                        r_state      <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (flush_valid) begin
                        r_pc         <= flush_pc;
                        r_redirected <= 1'b1;
                        r_pend_valid <= 1'b0;
                    end else if (!halt && resume) begin
                        r_state  <= r_pend_valid ? ST_PEND : ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_REDIR_CNT_EN
    logic [31:0] r_redir_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redir_cnt <= '0;
        end else if (r_redirected && (r_redir_cnt != 32'hFFFF_FFFF)) begin
            r_redir_cnt <= r_redir_cnt + 32'd1;
        end
    end

    assign redir_cnt = r_redir_cnt;
`endif

    assign pc         = r_pc;
    assign imem_addr  = r_pc[IMEM_AW-1:0];
    assign redirected = r_redirected;
    assign halted     = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;
    import pc_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic        redir;
        logic        hlt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redir_valid, cond_taken, flush_valid, halt, resume;
    logic [1:0]  redir_sel;
    logic [31:0] instr, dec_pc4, reg_a, flush_pc;
    logic [31:0] pc;
    logic [11:0] imem_addr;
    logic        redirected, halted;
`ifdef PC_REDIR_CNT_EN
    logic [31:0] redir_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   exp_redirs = 0;
    exp_t sb[$];
    exp_t e;

    pc_sequencer #(.PC_W(32), .IMEM_AW(12), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_sel   (redir_sel),
        .cond_taken  (cond_taken),
        .instr       (instr),
        .dec_pc4     (dec_pc4),
        .reg_a       (reg_a),
        .flush_valid (flush_valid),
        .flush_pc    (flush_pc),
        .halt        (halt),
        .resume      (resume),
        .pc          (pc),
        .imem_addr   (imem_addr),
        .redirected  (redirected),
        .halted      (halted)
`ifdef PC_REDIR_CNT_EN
        ,
        .redir_cnt   (redir_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle();
        stall = 0; redir_valid = 0; redir_sel = SEL_SEQ; cond_taken = 0;
        instr = 32'h0; dec_pc4 = 32'h0; reg_a = 32'h0;
        flush_valid = 0; flush_pc = 32'h0; halt = 0; resume = 0;
    endtask

    task automatic redir(input logic [1:0] sel, input logic ct, input logic [31:0] ins,
                         input logic [31:0] pc4, input logic [31:0] ra);
        redir_valid = 1; redir_sel = sel; cond_taken = ct;
        instr = ins; dec_pc4 = pc4; reg_a = ra;
    endtask

    task automatic expect_after(input logic [31:0] p, input logic r, input logic h);
        exp_t x;
        x.pc = p; x.redir = r; x.hlt = h;
        sb.push_back(x);
        if (r) exp_redirs++;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        tick(); tick();
        checks++;
        if (pc !== 32'h0 || imem_addr !== 12'h0 || redirected !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h imem=%h redirected=%b halted=%b expected pc=0 imem=0 redirected=0 halted=0",
                     pc, imem_addr, redirected, halted);
        end
        rst_n = 1;
        for (int k = 1; k <= 3; k++) begin
            expect_after(32'(4 * k), 0, 0);
            tick();
            e = sb.pop_front(); checks++;
            if (pc !== e.pc || redirected !== e.redir || halted !== e.hlt || imem_addr !== e.pc[11:0]) begin
                errors++;
                $display("FAIL reset_seq step %0d: pc=%h redirected=%b halted=%b expected pc=%h redirected=%b halted=%b",
                         k, pc, redirected, halted, e.pc, e.redir, e.hlt);
            end
        end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 4; k++) begin
            idle();
            case (k)
                0: begin redir(SEL_BRANCH, 1, 32'h0000_FFFC, 32'h100, 0); expect_after(32'hF0, 1, 0); end
                1: expect_after(32'hF4, 0, 0);
                2: begin redir(SEL_BRANCH, 0, 32'h0000_FFFC, 32'h100, 0); expect_after(32'hF8, 0, 0); end
                default: begin redir(SEL_SEQ, 1, 32'h0000_0010, 32'h100, 0); expect_after(32'hFC, 0, 0); end
            endcase
            tick();
            e = sb.pop_front(); checks++;
            if (pc !== e.pc || redirected !== e.redir || halted !== e.hlt) begin
                errors++;
                $display("FAIL branch step %0d: pc=%h redirected=%b halted=%b expected pc=%h redirected=%b halted=%b",
                         k, pc, redirected, halted, e.pc, e.redir, e.hlt);
            end
        end
    endtask

    task automatic test_jump_wrap();
        for (int k = 0; k < 5; k++) begin
            idle();
            case (k)
                0: begin redir(SEL_J, 0, 32'h0800_0040, 32'h1000_0004, 0); expect_after(32'h1000_0100, 1, 0); end
                1: begin redir(SEL_JR, 0, 32'h0, 32'h1000_0104, 32'h203); expect_after(32'h200, 1, 0); end
                2: begin flush_valid = 1; flush_pc = 32'hFFFF_FFFC; expect_after(32'hFFFF_FFFC, 1, 0); end
                3: expect_after(32'h0, 0, 0);
                default: expect_after(32'h4, 0, 0);
            endcase
            tick();
            e = sb.pop_front(); checks++;
            if (pc !== e.pc || redirected !== e.redir || halted !== e.hlt) begin
                errors++;
                $display("FAIL jump_wrap step %0d: pc=%h redirected=%b halted=%b expected pc=%h redirected=%b halted=%b",
                         k, pc, redirected, halted, e.pc, e.redir, e.hlt);
            end
        end
    endtask

    task automatic test_stalled_redirect();
        for (int k = 0; k < 5; k++) begin
            idle();
            case (k)
                0: begin stall = 1; redir(SEL_J, 0, 32'h0000_0020, 32'h8, 0); expect_after(32'h4, 0, 0); end
                1: begin stall = 1; redir(SEL_J, 0, 32'h0000_0100, 32'h8, 0); expect_after(32'h4, 0, 0); end
                2: begin stall = 1; expect_after(32'h4, 0, 0); end
                3: expect_after(32'h80, 1, 0);
                default: expect_after(32'h84, 0, 0);
            endcase
            tick();
            e = sb.pop_front(); checks++;
            if (pc !== e.pc || redirected !== e.redir || halted !== e.hlt) begin
                errors++;
                $display("FAIL stalled_redir step %0d: pc=%h redirected=%b halted=%b expected pc=%h redirected=%b halted=%b",
                         k, pc, redirected, halted, e.pc, e.redir, e.hlt);
            end
            if (k == 0) begin
                checks++;
                if (dut.r_state !== ST_PEND) begin
                    errors++;
                    $display("FAIL stalled_redir_state: state=%0d expected %0d", dut.r_state, ST_PEND);
                end
            end
        end
    endtask

    task automatic test_priority_halt();
        for (int k = 0; k < 14; k++) begin
            idle();
            case (k)
                0: begin redir(SEL_BRANCH, 1, 32'h0000_FFFC, 32'h100, 0);
                         flush_valid = 1; flush_pc = 32'h180; expect_after(32'h180, 1, 0); end
                1: expect_after(32'h184, 0, 0);
                2: begin halt = 1; expect_after(32'h184, 0, 1); end
                3: begin halt = 1; resume = 1; expect_after(32'h184, 0, 1); end
                4: begin resume = 1; expect_after(32'h184, 0, 0); end
                5: expect_after(32'h188, 0, 0);
                6: begin stall = 1; redir(SEL_J, 0, 32'h0000_00C0, 32'h10, 0); expect_after(32'h188, 0, 0); end
                7: begin stall = 1; halt = 1; expect_after(32'h188, 0, 1); end
                8: begin stall = 1; resume = 1; expect_after(32'h188, 0, 0); end
                9: expect_after(32'h300, 1, 0);
                10: begin halt = 1; expect_after(32'h300, 0, 1); end
                11: begin halt = 1; flush_valid = 1; flush_pc = 32'h40; expect_after(32'h40, 1, 1); end
                12: begin resume = 1; expect_after(32'h40, 0, 0); end
                default: expect_after(32'h44, 0, 0);
            endcase
            tick();
            e = sb.pop_front(); checks++;
            if (pc !== e.pc || redirected !== e.redir || halted !== e.hlt) begin
                errors++;
                $display("FAIL priority_halt step %0d: pc=%h redirected=%b halted=%b expected pc=%h redirected=%b halted=%b",
                         k, pc, redirected, halted, e.pc, e.redir, e.hlt);
            end
        end
    endtask

`ifdef PC_REDIR_CNT_EN
    task automatic test_redir_cnt();
        checks++;
        if (redir_cnt !== 32'(exp_redirs)) begin
            errors++;
            $display("FAIL redir_cnt: got %0d expected %0d", redir_cnt, exp_redirs);
        end
    endtask
`endif

    task automatic test_reset_mid_pend();
        idle();
        stall = 1; redir(SEL_J, 0, 32'h0000_0020, 32'h8, 0);
        expect_after(32'h44, 0, 0);
        tick();
        e = sb.pop_front(); checks++;
        if (pc !== e.pc || redirected !== e.redir || dut.r_state !== ST_PEND) begin
            errors++;
            $display("FAIL mid_pend_enter: pc=%h redirected=%b state=%0d expected pc=%h redirected=%b state=%0d",
                     pc, redirected, dut.r_state, e.pc, e.redir, ST_PEND);
        end
        rst_n = 0;
        #1;
        checks++;
        if (pc !== 32'h0 || halted !== 1'b0 || redirected !== 1'b0 || dut.r_pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_pend_reset: pc=%h halted=%b redirected=%b pend_valid=%b expected pc=0 halted=0 redirected=0 pend_valid=0",
                     pc, halted, redirected, dut.r_pend_valid);
        end
        tick();
        rst_n = 1;
        exp_redirs = 0;
        idle();
        for (int k = 1; k <= 2; k++) begin
            expect_after(32'(4 * k), 0, 0);
            tick();
            e = sb.pop_front(); checks++;
            if (pc !== e.pc || redirected !== e.redir || halted !== e.hlt) begin
                errors++;
                $display("FAIL mid_pend_after step %0d: pc=%h redirected=%b halted=%b expected pc=%h redirected=%b halted=%b",
                         k, pc, redirected, halted, e.pc, e.redir, e.hlt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump_wrap();
        test_stalled_redirect();
        test_priority_halt();
`ifdef PC_REDIR_CNT_EN
        test_redir_cnt();
`endif
        test_reset_mid_pend();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
